timer_cmp_irq: RTL and testbench
================================

// Module: timer_cmp_irq
// PURPOSE
// Compare/interrupt stage directly downstream of the free-running timer peripheral.
// Consumes the 32-bit timer count (TIME_IN) and raises a level interrupt to the Ibex core when the count equals a programmable compare value.
// Supports one-shot and periodic (auto-reload) modes.
// Registers are reachable on the same split read/write peripheral bus as the timer.
// PARAMETERS
// address_width  14  width of READ_ADDR/WRITE_ADDR; only ADDR[3:2] decoded, upper bits alias
// data_width     2   data bus = 2^data_width bytes; only 2 (32-bit) supported
// PORTS
// CLK         in   1    clock
// RSTn        in   1    reset, synchronous, active-low
// READ_ADDR   in   14   byte read address
// OE          in   1    read strobe, one cycle per read
// DATA_OUT    out  32   read data, registered
// DATA_VALID  out  1    read data valid, one cycle after OE
// WRITE_ADDR  in   14   byte write address
// DATA_IN     in   32   write data
// BE          in   4    byte enables for DATA_IN
// WE          in   1    write strobe
// WACK        out  1    write acknowledge, one cycle after WE && |BE
// TIME_IN     in   32   free-running count from timer, +1 per CLK, wraps 2^32-1 -> 0
// IRQ         out  1    level interrupt = PENDING & IE
// BEHAVIOUR
// Register map (byte offset; reset value 0 for all):
// - 0x0 CTRL: [0] EN, [1] PERIODIC, [2] IE; [31:3] read 0
// - 0x4 CMP: compare value
// - 0x8 PERIOD: reload increment
// - 0xC STATUS: [0] PENDING, [1] OVERRUN; both W1C, writes of 0 have no effect
// Writes:
// - Byte-granular per BE, applied at the CLK edge where WE=1.
// - WACK pulses high the following cycle, once per write cycle.
// Reads:
// - DATA_OUT captures the register value present at the OE edge (pre-write if a write hits the same cycle).
// - DATA_VALID=1 for exactly the next cycle; DATA_OUT holds otherwise.
// Match:
// - match = EN && (TIME_IN == CMP), evaluated every edge.
// - Equality compare only; wrap-safe because TIME_IN steps by 1.
// On match edge:
// - PENDING<=1.
// - If PENDING was already 1, OVERRUN<=1.
// - PERIODIC=1: CMP <= CMP + PERIOD (mod 2^32). PERIOD=0 means next match after 2^32 cycles.
// - PERIODIC=0: EN<=0 (one-shot).
// IRQ latency: IRQ is combinational from flops; high in the cycle after the match edge, and held until PENDING is cleared or IE=0.
// Simultaneous events:
// - Bus write to CMP/CTRL in the match cycle: bus write wins for the written bytes; PENDING still set.
// - W1C of PENDING in the match cycle: set wins, PENDING stays 1.
// - Enabling EN with CMP == current TIME_IN: match on that edge is ignored (EN uses the old value); next match after wrap.
// Reset (any cycle, including mid-read/write): all registers 0; DATA_OUT=0, DATA_VALID=0, WACK=0, IRQ=0; in-flight read/write dropped.
// Unmapped bits read 0; no bus errors.
// STRUCTURE
// Package timer_irq_pkg:
// - offsets CTRL_OFS=0, CMP_OFS=4, PERIOD_OFS=8, STATUS_OFS=12
// - CTRL bit indices EN_BIT, PERIODIC_BIT, IE_BIT; STATUS bit indices PEND_BIT, OVR_BIT
// - typedef ctrl_t (packed struct)
// Sub-module timer_cmp_unit: compare, reload adder, PENDING/OVERRUN/EN-clear logic.
// The top level holds bus decode, byte-enable writes and read mux/regs.
// TESTING
// One-shot: CMP=100, CTRL=0x5, TIME_IN reaches 100 -> IRQ high from cycle TIME_IN=101; EN reads 0; no second IRQ after wrap.
// Periodic: CMP=50, PERIOD=20, CTRL=0x7; clear PENDING each IRQ -> IRQs at TIME_IN 51,71,91; CMP reads 110 after third match.
// Overrun: periodic PERIOD=10, never clear -> STATUS=0x3 after second match; W1C 0x3 -> STATUS=0, IRQ low next cycle.
// Collision: W1C PENDING in exact match cycle -> PENDING stays 1; CMP write 0xFFFF_FFFF in match cycle -> CMP reads 0xFFFF_FFFF.
// Bus: BE=0x2 write 0xAABBCCDD to CMP=0 -> CMP=0x0000CC00; WACK one cycle later; OE read -> DATA_VALID one cycle, DATA_OUT=0x0000CC00.
// Reset mid-op: RSTn=0 while IRQ=1 and OE=1 -> next cycle IRQ=0, DATA_VALID=0, WACK=0, all registers read 0.

Source files
------------

// File: rtl/timer_cmp_irq_pkg.sv
// Shared register map, bit positions and helpers for the timer compare/interrupt block.
package timer_irq_pkg;

    localparam logic [3:0] CTRL_OFS   = 4'h0;
    localparam logic [3:0] CMP_OFS    = 4'h4;
    localparam logic [3:0] PERIOD_OFS = 4'h8;
    localparam logic [3:0] STATUS_OFS = 4'hC;

    localparam int EN_BIT       = 0;
    localparam int PERIODIC_BIT = 1;
    localparam int IE_BIT       = 2;
    localparam int PEND_BIT     = 0;
    localparam int OVR_BIT      = 1;

    // Word select taken from ADDR[3:2]; higher address bits alias.
    typedef enum logic [1:0] {
        SEL_CTRL   = CTRL_OFS[3:2],
        SEL_CMP    = CMP_OFS[3:2],
        SEL_PERIOD = PERIOD_OFS[3:2],
        SEL_STATUS = STATUS_OFS[3:2]
    } reg_sel_e;

    typedef struct packed {
        logic ie;
        logic periodic;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++)
            if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/timer_cmp_irq_if.sv
// Split read/write peripheral bus shared with the timer block.
interface timer_cmp_irq_if #(
    parameter int address_width = 14,
    parameter int data_width    = 2
);
    localparam int DW = 8 << data_width;

    logic [address_width-1:0] READ_ADDR;
    logic                     OE;
    logic [DW-1:0]            DATA_OUT;
    logic                     DATA_VALID;
    logic [address_width-1:0] WRITE_ADDR;
    logic [DW-1:0]            DATA_IN;
    logic [DW/8-1:0]          BE;
    logic                     WE;
    logic                     WACK;

    modport master (
        output READ_ADDR, OE, WRITE_ADDR, DATA_IN, BE, WE,
        input  DATA_OUT, DATA_VALID, WACK
    );

    modport slave (
        input  READ_ADDR, OE, WRITE_ADDR, DATA_IN, BE, WE,
        output DATA_OUT, DATA_VALID, WACK
    );
endinterface

// File: rtl/timer_cmp_irq_cmp_unit.sv
// Equality compare against the timer count, periodic reload and PENDING/OVERRUN flags.
module timer_cmp_unit
    import timer_irq_pkg::*;
(
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        en,
    input  logic        periodic,
    input  logic [31:0] time_in,
    input  logic [31:0] cmp_val,
    input  logic [31:0] period_val,
    input  logic [1:0]  w1c,
    output logic        match,
    output logic [31:0] cmp_next,
    output logic        en_clr,
    output logic        pending,
    output logic        overrun
);

    // Modular add: PERIOD=0 naturally yields a full 2^32-cycle period.
    function automatic logic [31:0] reload_add(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

    assign match    = en && (time_in == cmp_val);
    assign cmp_next = (match && periodic) ? reload_add(cmp_val, period_val) : cmp_val;
    assign en_clr   = match && !periodic;

    // Hardware set has priority over a same-cycle W1C.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (match)              pending <= 1'b1;
            else if (w1c[PEND_BIT]) pending <= 1'b0;

            if (match && pending)   overrun <= 1'b1;
            else if (w1c[OVR_BIT])  overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_cmp_irq.sv
// Compare/interrupt stage behind the free-running timer: bus decode, register file, read path.
module timer_cmp_irq
    import timer_irq_pkg::*;
#(
    parameter int address_width = 14,
    parameter int data_width    = 2     // only 32-bit data bus is supported
)(
    input  logic               CLK,
    input  logic               RSTn,
    timer_cmp_irq_if.slave     bus,
    input  logic [31:0]        TIME_IN,
    output logic               IRQ
);

    localparam int DW = 8 << data_width;

    ctrl_t          ctrl;
    logic [DW-1:0]  cmp_val;
    logic [DW-1:0]  period_val;
    logic           pending;
    logic           overrun;
    logic           match;
    logic           en_clr;
    logic [DW-1:0]  cmp_next;
    logic [DW-1:0]  rd_mux;
    logic [DW-1:0]  rd_data_p1;
    logic           rd_vld_p1;
    logic           wack_p1;
    logic           wr_fire;
    logic [1:0]     w1c;
    reg_sel_e       wsel;
    reg_sel_e       rsel;
    logic           unused_addr_bits;

    assign wsel    = reg_sel_e'(bus.WRITE_ADDR[3:2]);
    assign rsel    = reg_sel_e'(bus.READ_ADDR[3:2]);
    assign wr_fire = bus.WE && (|bus.BE);
    assign w1c     = (bus.WE && (wsel == SEL_STATUS) && bus.BE[0]) ? bus.DATA_IN[1:0] : 2'b00;

    assign unused_addr_bits = ^{bus.READ_ADDR[address_width-1:4], bus.READ_ADDR[1:0],
                                bus.WRITE_ADDR[address_width-1:4], bus.WRITE_ADDR[1:0], match};

    timer_cmp_unit u_cmp (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .en         (ctrl.en),
        .periodic   (ctrl.periodic),
        .time_in    (TIME_IN),
        .cmp_val    (cmp_val),
        .period_val (period_val),
        .w1c        (w1c),
        .match      (match),
        .cmp_next   (cmp_next),
        .en_clr     (en_clr),
        .pending    (pending),
        .overrun    (overrun)
    );

    always_comb begin
        rd_mux = '0;
        case (rsel)
            SEL_CTRL: begin
                rd_mux[EN_BIT]       = ctrl.en;
                rd_mux[PERIODIC_BIT] = ctrl.periodic;
                rd_mux[IE_BIT]       = ctrl.ie;
            end
            SEL_CMP:    rd_mux = cmp_val;
            SEL_PERIOD: rd_mux = period_val;
            default: begin
                rd_mux[PEND_BIT] = pending;
                rd_mux[OVR_BIT]  = overrun;
            end
        endcase
    end

    // Stage p1: registered read data, write ack and register updates (bus bytes beat hardware updates).
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            ctrl       <= '0;
            cmp_val    <= '0;
            period_val <= '0;
            rd_data_p1 <= '0;
            rd_vld_p1  <= 1'b0;
            wack_p1    <= 1'b0;
        end else begin
            rd_vld_p1 <= bus.OE;
            if (bus.OE) rd_data_p1 <= rd_mux;
            wack_p1 <= wr_fire;

            if (wr_fire && (wsel == SEL_CTRL) && bus.BE[0])
                ctrl <= '{ie:       bus.DATA_IN[IE_BIT],
                          periodic: bus.DATA_IN[PERIODIC_BIT],
                          en:       bus.DATA_IN[EN_BIT]};
            else if (en_clr)
                ctrl.en <= 1'b0;

            cmp_val <= (wr_fire && (wsel == SEL_CMP)) ? be_merge(cmp_next, bus.DATA_IN, bus.BE)
                                                       : cmp_next;
            if (wr_fire && (wsel == SEL_PERIOD))
                period_val <= be_merge(period_val, bus.DATA_IN, bus.BE);
        end
    end

    assign bus.DATA_OUT   = rd_data_p1;
    assign bus.DATA_VALID = rd_vld_p1;
    assign bus.WACK       = wack_p1;
    assign IRQ            = pending & ctrl.ie;

endmodule

// File: tb/tb_timer_cmp_irq.sv
// Directed bench for timer_cmp_irq with a register-level reference model and per-cycle output compare.
module tb_timer_cmp_irq;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [31:0] tm = 32'd0;
    logic [31:0] tm_ld_val = 32'd0;
    logic        tm_ld = 1'b0;
    logic        IRQ;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] rd;

    timer_cmp_irq_if #(.address_width(14), .data_width(2)) bus ();

    timer_cmp_irq #(.address_width(14), .data_width(2)) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .bus     (bus),
        .TIME_IN (tm),
        .IRQ     (IRQ)
    );

    always #5 CLK = ~CLK;

    // Free-running count, with an occasional load to skip ahead.
    always @(posedge CLK) tm <= tm_ld ? tm_ld_val : tm + 32'd1;

    // Reference model: architectural register state.
    logic        m_en, m_per, m_ie, m_pend, m_ovr, m_dv, m_wack;
    logic [31:0] m_cmp, m_period, m_dout;
    bit          started = 1'b0;

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {29'd0, m_ie, m_per, m_en};
            2'd1:    return m_cmp;
            2'd2:    return m_period;
            default: return {30'd0, m_ovr, m_pend};
        endcase
    endfunction

    always @(posedge CLK) begin : model
        logic        hit, n_en, n_per, n_ie, n_pend, n_ovr;
        logic [31:0] n_cmp, n_period;
        if (!RSTn) begin
            {m_en, m_per, m_ie, m_pend, m_ovr, m_dv, m_wack} = '0;
            m_cmp = '0; m_period = '0; m_dout = '0;
            started = 1'b1;
        end else begin
            hit      = m_en && (tm == m_cmp);
            n_en     = (hit && !m_per) ? 1'b0 : m_en;
            n_per    = m_per;
            n_ie     = m_ie;
            n_cmp    = (hit && m_per) ? m_cmp + m_period : m_cmp;
            n_period = m_period;
            n_pend   = m_pend;
            n_ovr    = m_ovr;
            m_dv     = bus.OE;
            if (bus.OE) m_dout = m_read(bus.READ_ADDR[3:2]);
            m_wack   = bus.WE && (bus.BE != 4'd0);
            if (bus.WE) begin
                case (bus.WRITE_ADDR[3:2])
                    2'd0: if (bus.BE[0]) {n_ie, n_per, n_en} = bus.DATA_IN[2:0];
                    2'd1: for (int b = 0; b < 4; b++)
                              if (bus.BE[b]) n_cmp[8*b +: 8] = bus.DATA_IN[8*b +: 8];
                    2'd2: for (int b = 0; b < 4; b++)
                              if (bus.BE[b]) n_period[8*b +: 8] = bus.DATA_IN[8*b +: 8];
                    default: if (bus.BE[0]) begin
                        if (bus.DATA_IN[0]) n_pend = 1'b0;
                        if (bus.DATA_IN[1]) n_ovr  = 1'b0;
                    end
                endcase
            end
            if (hit) begin
                if (m_pend) n_ovr = 1'b1;
                n_pend = 1'b1;
            end
            m_en = n_en; m_per = n_per; m_ie = n_ie; m_cmp = n_cmp;
            m_period = n_period; m_pend = n_pend; m_ovr = n_ovr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t TIME_IN=%0d)", name, act, exp, $time, tm);
    endtask

    always @(negedge CLK) begin
        if (started) begin
            chk("irq_model",    {31'd0, IRQ},            {31'd0, m_pend & m_ie});
            chk("dvalid_model", {31'd0, bus.DATA_VALID}, {31'd0, m_dv});
            chk("wack_model",   {31'd0, bus.WACK},       {31'd0, m_wack});
            chk("dout_model",   bus.DATA_OUT,            m_dout);
        end
    end

    task automatic bus_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge CLK); #1;
        bus.WE = 1'b1; bus.WRITE_ADDR = a; bus.DATA_IN = d; bus.BE = be;
        @(posedge CLK); #1;
        bus.WE = 1'b0; bus.BE = 4'd0;
    endtask

    task automatic bus_read(input logic [13:0] a, output logic [31:0] d);
        @(posedge CLK); #1;
        bus.OE = 1'b1; bus.READ_ADDR = a;
        @(posedge CLK); #1;
        bus.OE = 1'b0;
        @(negedge CLK);
        d = bus.DATA_OUT;
    endtask

    task automatic rd_chk(input string name, input logic [13:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(name, d, exp);
    endtask

    task automatic jump(input logic [31:0] v);
        @(posedge CLK); #1;
        tm_ld = 1'b1; tm_ld_val = v;
        @(posedge CLK); #1;
        tm_ld = 1'b0;
    endtask

    task automatic wait_tm(input logic [31:0] v);
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (tm == v) return;
        end
        chk("wait_timeout", tm, v);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1; RSTn = 1'b0;
        @(posedge CLK); #1; RSTn = 1'b1;
    endtask

    initial begin
        bus.OE = 1'b0; bus.WE = 1'b0; bus.BE = 4'd0;
        bus.READ_ADDR = '0; bus.WRITE_ADDR = '0; bus.DATA_IN = '0;
        repeat (2) @(posedge CLK);
        #1 RSTn = 1'b1;

        // Reset state
        chk("irq_reset", {31'd0, IRQ}, 32'd0);
        rd_chk("ctrl_reset",   14'h0, 32'd0);
        rd_chk("cmp_reset",    14'h4, 32'd0);
        rd_chk("period_reset", 14'h8, 32'd0);
        rd_chk("status_reset", 14'hC, 32'd0);

        // Byte-enable write through an aliased address, ack and read timing
        bus_write(14'h1004, 32'hAABBCCDD, 4'h2);
        @(negedge CLK); chk("wack_pulse", {31'd0, bus.WACK}, 32'd1);
        @(negedge CLK); chk("wack_drop",  {31'd0, bus.WACK}, 32'd0);
        bus_read(14'h4, rd);
        chk("dvalid_pulse", {31'd0, bus.DATA_VALID}, 32'd1);
        chk("cmp_be_write", rd, 32'h0000CC00);
        @(negedge CLK);
        chk("dvalid_drop", {31'd0, bus.DATA_VALID}, 32'd0);
        chk("dout_hold",   bus.DATA_OUT, 32'h0000CC00);

        // One-shot
        do_reset(); jump(32'h8000_0000);
        bus_write(14'h4, 32'd100, 4'hF);
        bus_write(14'h0, 32'h5, 4'hF);
        jump(32'd90);
        wait_tm(32'd100); chk("oneshot_pre", {31'd0, IRQ}, 32'd0);
        wait_tm(32'd101); chk("oneshot_irq", {31'd0, IRQ}, 32'd1);
        rd_chk("oneshot_ctrl",   14'h0, 32'h4);
        rd_chk("oneshot_status", 14'hC, 32'h1);
        bus_write(14'hC, 32'h1, 4'h1);
        jump(32'hFFFF_FF00);
        wait_tm(32'd200); chk("oneshot_nowrap", {31'd0, IRQ}, 32'd0);
        rd_chk("oneshot_status2", 14'hC, 32'h0);

        // Periodic with per-interrupt clear
        do_reset(); jump(32'h8000_0000);
        bus_write(14'h4, 32'd50, 4'hF);
        bus_write(14'h8, 32'd20, 4'hF);
        bus_write(14'h0, 32'h7, 4'hF);
        jump(32'd40);
        wait_tm(32'd50); chk("per_pre", {31'd0, IRQ}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            wait_tm(32'd51 + 32'd20 * k);
            chk("per_irq", {31'd0, IRQ}, 32'd1);
            bus_write(14'hC, 32'h1, 4'h1);
            chk("per_clr", {31'd0, IRQ}, 32'd0);
        end
        rd_chk("per_cmp",    14'h4, 32'd110);
        rd_chk("per_status", 14'hC, 32'h0);

        // Overrun
        do_reset(); jump(32'h8000_0000);
        bus_write(14'h4, 32'd50, 4'hF);
        bus_write(14'h8, 32'd10, 4'hF);
        bus_write(14'h0, 32'h7, 4'hF);
        jump(32'd45);
        wait_tm(32'd61);
        rd_chk("ovr_status", 14'hC, 32'h3);
        chk("ovr_irq", {31'd0, IRQ}, 32'd1);
        bus_write(14'hC, 32'h3, 4'h1);
        @(negedge CLK); chk("ovr_irq_clr", {31'd0, IRQ}, 32'd0);
        rd_chk("ovr_status_clr", 14'hC, 32'h0);

        // Collisions with the match edge
        do_reset(); jump(32'h8000_0000);
        bus_write(14'h4, 32'd100, 4'hF);
        bus_write(14'h8, 32'd10, 4'hF);
        bus_write(14'h0, 32'h7, 4'hF);
        jump(32'd95);
        wait_tm(32'd109);
        bus_write(14'hC, 32'h1, 4'h1);
        rd_chk("col_w1c_status", 14'hC, 32'h3);
        chk("col_irq", {31'd0, IRQ}, 32'd1);
        wait_tm(32'd119);
        bus_write(14'h4, 32'hFFFF_FFFF, 4'hF);
        rd_chk("col_cmp", 14'h4, 32'hFFFF_FFFF);

        // Reset while IRQ is high and a read/write is in flight
        chk("rst_pre_irq", {31'd0, IRQ}, 32'd1);
        @(posedge CLK); #1;
        RSTn = 1'b0; bus.OE = 1'b1; bus.READ_ADDR = 14'h4;
        bus.WE = 1'b1; bus.WRITE_ADDR = 14'h8; bus.DATA_IN = 32'h1234; bus.BE = 4'hF;
        @(posedge CLK); #1;
        chk("rst_irq",    {31'd0, IRQ},            32'd0);
        chk("rst_dvalid", {31'd0, bus.DATA_VALID}, 32'd0);
        chk("rst_wack",   {31'd0, bus.WACK},       32'd0);
        bus.OE = 1'b0; bus.WE = 1'b0; bus.BE = 4'd0; RSTn = 1'b1;
        rd_chk("rst_ctrl",   14'h0, 32'd0);
        rd_chk("rst_cmp",    14'h4, 32'd0);
        rd_chk("rst_period", 14'h8, 32'd0);
        rd_chk("rst_status", 14'hC, 32'd0);

        // Enabling in the very cycle TIME_IN equals CMP does not match
        jump(32'h8000_0000);
        bus_write(14'h4, 32'd300, 4'hF);
        jump(32'd290);
        wait_tm(32'd299);
        bus_write(14'h0, 32'h5, 4'h1);
        wait_tm(32'd302); chk("en_same_cycle", {31'd0, IRQ}, 32'd0);
        rd_chk("en_same_status", 14'hC, 32'h0);
        rd_chk("en_same_ctrl",   14'h0, 32'h5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
